// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one reused full-adder cell built from gate primitives,
// LSB first, with a registered carry and a start/busy/done handshake.

module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, rs;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             half_x, s, gen, prop, co;
  logic             last;

  xor2 u_xor_ab  (.a(ra[0]), .b(rb[0]),  .y(half_x));
  xor2 u_xor_s   (.a(half_x), .b(c),     .y(s));
  and2 u_and_gen (.a(ra[0]), .b(rb[0]),  .y(gen));
  and2 u_and_prp (.a(c),      .b(half_x), .y(prop));
  or2  u_or_co   (.a(gen),    .b(prop),  .y(co));

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand/result shifters; sum and cout move only on the final RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra   <= '0;
      rb   <= '0;
      rs   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            c   <= cin;
            cnt <= '0;
          end
        end
        RUN: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          rs  <= {s, rs[WIDTH-1:1]};
          c   <= co;
          cnt <= cnt + 1'b1;
          if (last) begin
            sum  <= {s, rs[WIDTH-1:1]};
            cout <= co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: 8-bit directed scenarios plus a
// randomized 4-bit instance against a reference sum.

module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] last8;
  logic [4:0] last4;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic test_reset();
    reset = 1'b1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start4 = 1'b1; a4 = 4'hF;  b4 = 4'hF;  cin4 = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b cout=%b sum=%h, required all zero",
               busy8, done8, cout8, sum8);
    end
    n_tests++;
    if ({busy4, done4, cout4, sum4} !== 7'h00) begin
      n_fail++;
      $display("FAIL reset4: busy=%b done=%b cout=%b sum=%h, required all zero",
               busy4, done4, cout4, sum4);
    end
    reset = 1'b0; start8 = 1'b0; start4 = 1'b0;
    last8 = '0; last4 = '0;
    @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_beats_start: busy=%b, required 0", busy8);
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] exp, got;
    int cyc;
    bit ok;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    cyc = 1;
    n_tests++;
    if (busy8 !== 1'b1 || {cout8, sum8} !== last8) begin
      n_fail++;
      $display("FAIL run_hold8: busy=%b result=%h, required busy=1 result=%h",
               busy8, {cout8, sum8}, last8);
    end
    ok = (done8 === 1'b1);
    while (!ok && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ok = (done8 === 1'b1);
    end
    n_tests++;
    if (!ok || cyc != 9) begin
      n_fail++;
      $display("FAIL latency8: done after %0d cycles (seen=%0d), required 9", cyc, ok);
    end
    if (q8.size() > 0) begin
      exp = q8.pop_front();
      got = {cout8, sum8};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sum8 %h+%h+%b: got %h, required %h", a, b, cin, got, exp);
      end
      last8 = exp;
    end
    @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle8: busy=%b done=%b, required 0 0", busy8, done8);
    end
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] exp, got;
    int cyc;
    bit ok;
    @(negedge clk);
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
    q4.push_back({1'b0, a} + {1'b0, b} + 5'(cin));
    @(negedge clk);
    start4 = 1'b1;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    cyc = 1;
    n_tests++;
    if (busy4 !== 1'b1 || {cout4, sum4} !== last4) begin
      n_fail++;
      $display("FAIL run_hold4: busy=%b result=%h, required busy=1 result=%h",
               busy4, {cout4, sum4}, last4);
    end
    ok = (done4 === 1'b1);
    while (!ok && cyc < 30) begin
      @(negedge clk);
      cyc++;
      ok = (done4 === 1'b1);
    end
    start4 = 1'b0;
    n_tests++;
    if (!ok || cyc != 5) begin
      n_fail++;
      $display("FAIL latency4: done after %0d cycles (seen=%0d), required 5", cyc, ok);
    end
    if (q4.size() > 0) begin
      exp = q4.pop_front();
      got = {cout4, sum4};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sum4 %h+%h+%b: got %h, required %h", a, b, cin, got, exp);
      end
      last4 = exp;
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op8(8'h35, 8'h4A, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b1);
    run_op8(8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_change_during_run();
    int cyc;
    bit ok;
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h010);
    cyc = 0;
    ok = 1'b0;
    while (!ok && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) a8 = 8'hAA;
      ok = (done8 === 1'b1);
      n_tests++;
      if (busy8 !== 1'b1) begin
        n_fail++;
        $display("FAIL change_busy: cycle %0d busy=%b, required 1", cyc, busy8);
      end
    end
    n_tests++;
    if (!ok || cyc != 9) begin
      n_fail++;
      $display("FAIL change_latency: done after %0d cycles, required 9", cyc);
    end
    n_tests++;
    if ({cout8, sum8} !== q8[0]) begin
      n_fail++;
      $display("FAIL change_sum: got %h, required %h", {cout8, sum8}, q8[0]);
    end
    last8 = q8.pop_front();
    @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b done=%b, required 0 0", busy8, done8);
    end
    start8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h100);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b cout=%b sum=%h, required all zero",
               busy8, done8, cout8, sum8);
    end
    void'(q8.pop_front());
    last8 = '0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL mid_reset_done: %0d done pulses, required 0", pulses);
    end
    run_op8(8'h01, 8'h02, 1'b0);
  endtask

  task automatic test_back_to_back();
    int pulses, prev;
    logic [8:0] exp;
    pulses = 0;
    prev = -1;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) @(negedge clk);
      if (done8 === 1'b1) begin
        pulses++;
        if (prev >= 0) begin
          n_tests++;
          if (i - prev != 10) begin
            n_fail++;
            $display("FAIL b2b_interval: %0d cycles, required 10", i - prev);
          end
        end
        prev = i;
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
        n_tests++;
        if ({cout8, sum8} !== exp) begin
          n_fail++;
          $display("FAIL b2b_sum: got %h, required %h", {cout8, sum8}, exp);
        end
      end
      if (i < 30) begin
        if (busy8 === 1'b0) q8.push_back(9'h030);
        start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    n_tests++;
    if (pulses != 3 || q8.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: %0d pulses, %0d pending, required 3 and 0",
               pulses, q8.size());
    end
    q8.delete();
    last8 = 9'h030;
    @(negedge clk);
  endtask

  task automatic test_random4();
    for (int i = 0; i < 200; i++)
      run_op4(4'($urandom), 4'($urandom), 1'($urandom));
    run_op4(4'hF, 4'hF, 1'b1);
    run_op4(4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    last8 = '0; last4 = '0;
    test_reset();
    test_basic();
    test_change_during_run();
    test_reset_mid_run();
    test_back_to_back();
    run_op8(8'h7F, 8'h80, 1'b1);
    test_random4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
